// File: rtl/sm_trace_pkg.sv
// Shared types and default sizing for the instruction trace buffer.
package sm_trace_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StArmed  = 2'd1,
    StPost   = 2'd2,
    StFrozen = 2'd3
  } trace_state_e;

  localparam int unsigned DefDepthLog2 = 4;
  localparam int unsigned DefPostTrig  = 8;

endpackage

// File: rtl/sm_trace_buf_if.sv
// Capture, control and readout signals of the trace buffer.
interface sm_trace_buf_if
  import sm_trace_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DefDepthLog2
);
  logic                  sample;
  logic [31:0]           pc;
  logic [31:0]           instr;
  logic                  arm;
  logic                  stop;
  logic                  trigEn;
  logic [31:0]           trigPc;
  logic [DEPTH_LOG2-1:0] rdAddr;
  logic [31:0]           rdPc;
  logic [31:0]           rdInstr;
  logic [1:0]            state;
  logic [DEPTH_LOG2:0]   count;
  logic                  trigged;

  modport master (
    output sample, pc, instr, arm, stop, trigEn, trigPc, rdAddr,
    input  rdPc, rdInstr, state, count, trigged
  );

  modport slave (
    input  sample, pc, instr, arm, stop, trigEn, trigPc, rdAddr,
    output rdPc, rdInstr, state, count, trigged
  );
endinterface

// File: rtl/sm_trace_ram.sv
// Simple dual-port RAM, synchronous read-before-write, no reset.
module sm_trace_ram #(
  parameter int unsigned AddrWidth = 4,
  parameter int unsigned DataWidth = 64
) (
  input  logic                 clk,
  input  logic                 wrEn,
  input  logic [AddrWidth-1:0] wrAddr,
  input  logic [DataWidth-1:0] wrData,
  input  logic [AddrWidth-1:0] rdAddr,
  output logic [DataWidth-1:0] rdData
);
  logic [DataWidth-1:0] mem [0:(1 << AddrWidth)-1];

  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
    rdData <= mem[rdAddr];
  end
endmodule

// File: rtl/sm_trace_buf.sv
// Circular PC/instruction trace buffer with PC-match trigger and post-trigger window.
module sm_trace_buf
  import sm_trace_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DefDepthLog2,
  parameter int unsigned POST_TRIG  = DefPostTrig
) (
  input logic           clk,
  input logic           rst,
  sm_trace_buf_if.slave bus
);
  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  localparam cnt_t CountMax = cnt_t'(Depth);
  localparam ptr_t PostLoad = ptr_t'(POST_TRIG);

  trace_state_e stateQ, stateD;
  ptr_t         wptrQ, wptrD;
  cnt_t         countQ, countD;
  ptr_t         postCntQ, postCntD;
  logic         trigQ, trigD;
  logic         rdValidQ;
  logic         wrEn;
  logic         trigHit;
  ptr_t         rdPhys;
  logic [63:0]  rdData;

  assign trigHit = bus.trigEn && (bus.pc == bus.trigPc);

  always_comb begin
    stateD   = stateQ;
    wptrD    = wptrQ;
    countD   = countQ;
    postCntD = postCntQ;
    trigD    = trigQ;
    wrEn     = 1'b0;

    if (bus.arm) begin
      // Arm restarts capture from any state and drops a coincident sample.
      stateD   = StArmed;
      wptrD    = '0;
      countD   = '0;
      postCntD = '0;
      trigD    = 1'b0;
    end else begin
      unique case (stateQ)
        StArmed: begin
          if (bus.sample) begin
            wrEn = 1'b1;
            if (trigHit) begin
              trigD    = 1'b1;
              postCntD = PostLoad;
              stateD   = (POST_TRIG == 0) ? StFrozen : StPost;
            end
          end
          if (bus.stop) begin
            stateD = StFrozen;
          end
        end
        StPost: begin
          if (bus.sample) begin
            wrEn     = 1'b1;
            postCntD = postCntQ - ptr_t'(1);
            if (postCntQ == ptr_t'(1)) begin
              stateD = StFrozen;
            end
          end
          if (bus.stop) begin
            stateD = StFrozen;
          end
        end
        default: ;
      endcase

      if (wrEn) begin
        wptrD = wptrQ + ptr_t'(1);
        if (countQ != CountMax) begin
          countD = countQ + cnt_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ   <= StIdle;
      wptrQ    <= '0;
      countQ   <= '0;
      postCntQ <= '0;
      trigQ    <= 1'b0;
      rdValidQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      wptrQ    <= wptrD;
      countQ   <= countD;
      postCntQ <= postCntD;
      trigQ    <= trigD;
      rdValidQ <= (cnt_t'(bus.rdAddr) < countQ);
    end
  end

  // Oldest entry sits count slots behind the write pointer; count==Depth wraps to wptr.
  assign rdPhys = wptrQ - ptr_t'(countQ) + bus.rdAddr;

  sm_trace_ram #(
    .AddrWidth(DEPTH_LOG2),
    .DataWidth(64)
  ) uRam (
    .clk   (clk),
    .wrEn  (wrEn),
    .wrAddr(wptrQ),
    .wrData({bus.pc, bus.instr}),
    .rdAddr(rdPhys),
    .rdData(rdData)
  );

  // Unreset RAM data is masked by the registered valid flag.
  assign bus.rdPc    = rdValidQ ? rdData[63:32] : 32'h0;
  assign bus.rdInstr = rdValidQ ? rdData[31:0]  : 32'h0;
  assign bus.state   = stateQ;
  assign bus.count   = countQ;
  assign bus.trigged = trigQ;
endmodule

// File: doc/sm_trace_buf.md
SM_TRACE_BUF -- requirements
Module: sm_trace_buf

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter DEPTH_LOG2, default 4, sets buffer depth DEPTH = 2^DEPTH_LOG2 entries.
REQ-003 Parameter POST_TRIG, default 8, sets entries captured after the trigger; legal range 0..DEPTH-1.
REQ-004 clk  in  1  CPU clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 sample  in  1  one pulse per executed instruction; qualifies pc/instr.
REQ-007 pc  in  32  word-address PC of the sampled instruction.
REQ-008 instr  in  32  instruction word of the sampled instruction.
REQ-009 arm  in  1  single-cycle pulse; clear and start capture.
REQ-010 stop  in  1  single-cycle pulse; force freeze.
REQ-011 trigEn  in  1  enables PC-match trigger.
REQ-012 trigPc  in  32  trigger PC value.
REQ-013 rdAddr  in  DEPTH_LOG2  logical read index; 0 = oldest stored entry.
REQ-014 rdPc  out  32  PC of the entry at rdAddr, registered.
REQ-015 rdInstr  out  32  instruction of the entry at rdAddr, registered.
REQ-016 state  out  2  IDLE=0, ARMED=1, POST=2, FROZEN=3.
REQ-017 count  out  DEPTH_LOG2+1  valid entries held, saturates at DEPTH.
REQ-018 trigged  out  1  set when a trigger match has occurred since the last arm.

Function
REQ-019 IDLE: no writes; arm moves to ARMED.
REQ-020 arm in any state SHALL clear wptr, count, trigged and postCnt, then enter ARMED on the same edge; sample in that cycle is discarded.
REQ-021 arm together with stop: arm wins, stop ignored.
REQ-022 ARMED: each sample writes {pc,instr} at wptr; wptr increments mod DEPTH (wrap overwrites oldest); count increments, saturating at DEPTH.
REQ-023 Trigger: in ARMED, sample && trigEn && pc==trigPc writes the entry, sets trigged, loads postCnt=POST_TRIG; next state POST, or FROZEN if POST_TRIG==0.
REQ-024 POST: each sample writes and decrements postCnt; the write that takes postCnt to 0 also enters FROZEN; trigger matches ignored.
REQ-025 stop in ARMED or POST enters FROZEN; a sample in the same cycle is still written first.
REQ-026 FROZEN: no writes, counters held; only arm leaves FROZEN.
REQ-027 stop in IDLE or FROZEN: no effect.
REQ-028 Readout: physical index = (wptr - count + rdAddr) mod DEPTH; rdPc/rdInstr valid one clk after rdAddr, in every state.
REQ-029 rdAddr >= count SHALL return rdPc=0, rdInstr=0.
REQ-030 Read and write to the same physical entry in one cycle returns pre-write contents.

Reset
REQ-031 rst SHALL force state=IDLE, wptr=0, count=0, postCnt=0, trigged=0, rdPc=0, rdInstr=0 immediately, including mid-capture.
REQ-032 Storage array contents SHALL NOT need reset; count=0 masks them per REQ-029.

Structure
REQ-033 Package sm_trace_pkg SHALL hold state encodings and default DEPTH_LOG2/POST_TRIG values.
REQ-034 Sub-module sm_trace_ram SHALL be a simple dual-port DEPTH x 64 RAM with synchronous read-before-write; no reset.

Verification
REQ-035 rst, arm, 5 samples pc=0..4, no trigger -> state=1, count=5, rdAddr=0 gives rdPc=0, rdAddr=4 gives rdPc=4.
REQ-036 arm, 20 samples pc=0..19 -> count=16; rdAddr=0 gives pc=4, rdAddr=15 gives pc=19.
REQ-037 trigEn=1, trigPc=10, arm, samples pc=0..30 -> trigged=1, state=3 after pc=18 write; count=16; rdAddr=15 gives pc=18, rdAddr=7 gives pc=10.
REQ-038 POST_TRIG=0, trigPc=3 -> FROZEN on the same edge as the pc=3 write; count=4; later samples ignored.
REQ-039 stop with sample pc=7 in ARMED -> pc=7 stored, state=3; then arm with stop -> state=1, count=0, trigged=0.
REQ-040 rst asserted mid-POST -> all outputs 0 and state=IDLE asynchronously; samples after release ignored until arm.
